// File: rtl/mem_latency_model_pkg.sv
// Shared entry layout, statistics limit and helpers for the simulation memory model.
// Default widths here also seed the top-level parameter defaults.
package mem_latency_model_pkg;

    localparam int          RESP_TAG_BITS  = 5;
    localparam int          RESP_DATA_BITS = 128;
    localparam logic [31:0] STAT_MAX       = 32'hFFFF_FFFF;

    typedef struct packed {
        logic                      nack;
        logic [RESP_TAG_BITS-1:0]  tag;
        logic [RESP_DATA_BITS-1:0] data;
    } resp_entry_t;

    function automatic bit params_legal(input int latency, input int depth, input int max_out);
        return (latency >= 1) && (latency <= 32)
            && (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (max_out >= 1) && (max_out <= latency + 8);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == STAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Valid/payload shift pipeline of STAGES registers; output is the last stage.
// Fixed STAGES-cycle latency, no backpressure; the async clear empties every stage.
module mem_delay_line
    import mem_latency_model_pkg::*;
#(
    parameter int  STAGES  = 4,
    parameter type entry_t = resp_entry_t
) (
    input  logic   i_clk,
    input  logic   i_clr_n,
    input  logic   i_vld,
    input  entry_t i_dat,
    output logic   o_vld,
    output entry_t o_dat
);

    logic [STAGES-1:0] r_vld;
    entry_t            r_dat [STAGES];

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_vld <= '0;
            for (int i = 0; i < STAGES; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_dat[0] <= i_dat;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_vld = r_vld[STAGES-1];
    assign o_dat = r_dat[STAGES-1];

endmodule

// File: rtl/mem_latency_model.sv
// Tagged memory model for the core mem_req/mem_resp port: storage, NACK injection, sticky OOB flag, stats.
// Loads respond in order LATENCY cycles after acceptance; rdy throttles at MAX_OUTSTANDING loads, no response backpressure.
module mem_latency_model
    import mem_latency_model_pkg::*;
#(
    parameter int ADDR_BITS       = 26,
    parameter int DATA_BITS       = RESP_DATA_BITS,
    parameter int TAG_BITS        = RESP_TAG_BITS,
    parameter int DEPTH_WORDS     = 4096,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int NACK_PERIOD     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_mem_req_val,
    output logic                 o_mem_req_rdy,
    input  logic                 i_mem_req_rw,
    input  logic [ADDR_BITS-1:0] i_mem_req_addr,
    input  logic [TAG_BITS-1:0]  i_mem_req_tag,
    input  logic [DATA_BITS-1:0] i_mem_req_data,
    output logic                 o_mem_resp_val,
    output logic                 o_mem_resp_nack,
    output logic [TAG_BITS-1:0]  o_mem_resp_tag,
    output logic [DATA_BITS-1:0] o_mem_resp_data,
    output logic                 o_err_oob,
    output logic [31:0]          o_stat_reads,
    output logic [31:0]          o_stat_writes,
    output logic [31:0]          o_stat_nacks
);

    localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam int CNT_BITS  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PH_BITS   = (NACK_PERIOD > 1) ? $clog2(NACK_PERIOD) : 1;
    localparam bit PARAMS_OK = params_legal(LATENCY, DEPTH_WORDS, MAX_OUTSTANDING);

    typedef struct packed {
        logic                 nack;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic [DATA_BITS-1:0] r_mem [DEPTH_WORDS];
    logic                 r_rdy;
    logic [CNT_BITS-1:0]  r_outstanding;
    logic                 r_err_oob;
    logic [31:0]          r_stat_reads;
    logic [31:0]          r_stat_writes;
    logic [31:0]          r_stat_nacks;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_store;
    logic                 w_oob;
    logic                 w_nack;
    logic                 w_resp_vld;
    logic [IDX_BITS-1:0]  w_idx;
    logic [CNT_BITS-1:0]  w_outstanding_nxt;
    entry_t               w_entry;
    entry_t               w_resp;

    assign w_accept = i_mem_req_val && r_rdy;
    assign w_load   = w_accept && !i_mem_req_rw;
    assign w_store  = w_accept &&  i_mem_req_rw;
    assign w_idx    = i_mem_req_addr[IDX_BITS-1:0];
    assign w_oob    = (i_mem_req_addr >> IDX_BITS) != '0;

    // Storage deliberately survives reset.
    always_ff @(posedge i_clk) begin
        if (w_store) r_mem[w_idx] <= i_mem_req_data;
    end

    generate
        if (NACK_PERIOD > 0) begin : g_nack
            logic [PH_BITS-1:0] r_phase;
            logic               w_wrap;

            assign w_wrap = (r_phase == PH_BITS'(NACK_PERIOD - 1));
            assign w_nack = w_load && w_wrap;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset)    r_phase <= '0;
                else if (w_load) r_phase <= w_wrap ? '0 : r_phase + PH_BITS'(1);
            end
        end else begin : g_no_nack
            assign w_nack = 1'b0;
        end
    endgenerate

    // Idle slots carry zeros so the response bus reads 0 between responses.
    always_comb begin
        w_entry      = '0;
        w_entry.nack = w_nack;
        if (w_load) begin
            w_entry.tag = i_mem_req_tag;
            if (!w_nack) w_entry.data = r_mem[w_idx];
        end
    end

    mem_delay_line #(
        .STAGES  (LATENCY),
        .entry_t (entry_t)
    ) u_delay (
        .i_clk   (i_clk),
        .i_clr_n (i_reset),
        .i_vld   (w_load),
        .i_dat   (w_entry),
        .o_vld   (w_resp_vld),
        .o_dat   (w_resp)
    );

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_load && !w_resp_vld)      w_outstanding_nxt = r_outstanding + CNT_BITS'(1);
        else if (!w_load && w_resp_vld) w_outstanding_nxt = r_outstanding - CNT_BITS'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdy         <= 1'b0;
            r_outstanding <= '0;
            r_err_oob     <= 1'b0;
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_nacks  <= '0;
        end else begin
            r_rdy         <= w_outstanding_nxt < CNT_BITS'(MAX_OUTSTANDING);
            r_outstanding <= w_outstanding_nxt;
            r_err_oob     <= r_err_oob || (w_accept && w_oob);
            if (w_load)                    r_stat_reads  <= sat_inc(r_stat_reads);
            if (w_store)                   r_stat_writes <= sat_inc(r_stat_writes);
            if (w_resp_vld && w_resp.nack) r_stat_nacks  <= sat_inc(r_stat_nacks);
        end
    end

    a_params_legal: assert property (@(posedge i_clk) PARAMS_OK);

    assign o_mem_req_rdy   = r_rdy;
    assign o_mem_resp_val  = w_resp_vld;
    assign o_mem_resp_nack = w_resp.nack;
    assign o_mem_resp_tag  = w_resp.tag;
    assign o_mem_resp_data = w_resp.data;
    assign o_err_oob       = r_err_oob;
    assign o_stat_reads    = r_stat_reads;
    assign o_stat_writes   = r_stat_writes;
    assign o_stat_nacks    = r_stat_nacks;

endmodule
